// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, keeps one ROM read in flight and
// buffers returned words in a small FIFO toward decode, flushing on redirects.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] fifo_pc   [FIFO_DEPTH];
    logic [31:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic        issue;
    logic        push;
    logic        pop;
    logic [31:0] target_pc;

    assign target_pc = redirect_pc & ~32'd3;
    assign issue     = (state == IDLE) && !redirect_valid && (count < DEPTH_C);
    assign push      = (state == WAIT) && mem_rvalid && !redirect_valid;
    assign pop       = inst_valid && inst_ready && !redirect_valid;

    // Request is decoded from registered state so the issue cycle and the
    // request coincide, giving the two-cycle issue/response cadence.
    assign mem_req    = issue && !reset;
    assign mem_addr   = {2'b00, pc[31:2]};
    assign inst_valid = (count != '0);
    assign inst_out   = inst_valid ? fifo_data[head] : '0;
    assign inst_pc    = inst_valid ? fifo_pc[head]   : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[tail]   <= req_pc;
            fifo_data[tail] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc <= target_pc;
                    end else if (issue) begin
                        req_pc <= pc;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                        pc    <= redirect_valid ? target_pc : pc + 32'd4;
                    end else if (redirect_valid) begin
                        pc    <= target_pc;
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (redirect_valid) pc <= target_pc;
                    if (mem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (redirect_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_ONE;
                if (pop)  head <= head + PTR_ONE;
                if (push && !pop)      count <= count + CNT_ONE;
                else if (pop && !push) count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based model of the fetch rules.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    imem_fetch_ctrl #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: program counter, one outstanding read, buffer queue
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_out;
    bit          m_stale;
    logic [63:0] m_q[$];

    // memory model
    bit          mem_pend, late_pend, rand_lat, spur_en;
    int          mem_due, late_due, cyc, lat, n_req;
    logic [31:0] mem_data;

    // last observed outputs
    logic        o_req, o_valid;
    logic [31:0] o_addr, o_out, o_pc;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'd0) return 32'h003100B3;
        if (a == 32'd1) return 32'h00628233;
        return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc = RESET_PC;
        m_out = 0;
        m_stale = 0;
    endtask

    // Called on a falling edge; drives one cycle, checks it, advances to next falling edge.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic        rvl, exp_req, exp_valid, push_now;
        logic [31:0] rdata, exp_out, exp_pc;
        int          sz0;
        rvl = 1'b0;
        rdata = $urandom;
        if (mem_pend && cyc == mem_due) begin
            rvl = 1'b1;
            rdata = mem_data;
        end else if (late_pend && cyc == late_due) begin
            rvl = 1'b1;
        end else if (spur_en && !mem_pend && !late_pend && $urandom_range(0, 99) < 3) begin
            rvl = 1'b1;
        end
        mem_rvalid = rvl;
        mem_rdata = rdata;
        redirect_valid = rv;
        redirect_pc = rpc;
        inst_ready = rdy;
        #1;
        sz0 = m_q.size();
        exp_req   = !m_out && !rv && (sz0 < DEPTH);
        exp_valid = (sz0 != 0);
        exp_out   = exp_valid ? m_q[0][31:0]  : 32'h0;
        exp_pc    = exp_valid ? m_q[0][63:32] : 32'h0;
        chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
        chk("mem_addr", mem_addr, m_pc >> 2);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
        chk("inst_out", inst_out, exp_out);
        chk("inst_pc", inst_pc, exp_pc);
        o_req = mem_req; o_addr = mem_addr; o_valid = inst_valid; o_out = inst_out; o_pc = inst_pc;

        if (rvl && mem_pend && cyc == mem_due) mem_pend = 0;
        if (late_pend && cyc == late_due) late_pend = 0;
        if (mem_req) begin
            mem_pend = 1;
            mem_due = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
            mem_data = rom(mem_addr);
            n_req++;
        end

        push_now = 0;
        if (rvl && m_out) begin
            m_out = 0;
            push_now = !m_stale && !rv;
            m_stale = 0;
        end
        if (rv) begin
            m_q.delete();
            m_pc = rpc & ~32'd3;
            if (m_out) m_stale = 1;
        end else begin
            if (rdy && sz0 > 0) void'(m_q.pop_front());
            if (push_now) begin
                m_q.push_back({m_req_pc, rom(m_req_pc >> 2)});
                m_pc = m_pc + 32'd4;
            end
        end
        if (exp_req) begin
            m_out = 1;
            m_stale = 0;
            m_req_pc = m_pc;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit late);
        reset = 1'b1;
        redirect_valid = 1'b0;
        mem_rvalid = 1'b0;
        inst_ready = 1'b0;
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, RESET_PC >> 2);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        late_pend = late && mem_pend;
        mem_pend = 0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b0;
        cyc = 0;
        late_due = 0;
        n_req = 0;
        model_reset();
    endtask

    task automatic run_until_req(input string tag, input logic rdy);
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 32'h0, rdy);
            if (o_req) break;
        end
        chk(tag, {31'b0, o_req}, 32'h1);
    endtask

    initial begin
        bit hit;
        lat = 1;
        rand_lat = 0;
        spur_en = 0;
        mem_pend = 0;
        late_pend = 0;
        @(negedge clk);

        // back-to-back fetch with 1-cycle memory
        do_reset(1'b0);
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 32'h0, 1'b1);
            if (c == 0) chk("t1_req_c0", {31'b0, o_req}, 32'h1);
            if (c == 1) chk("t1_noreq_c1", {31'b0, o_req}, 32'h0);
            if (c == 2) begin
                chk("t1_pc_c2", o_pc, 32'h0);
                chk("t1_inst_c2", o_out, 32'h003100B3);
                chk("t1_addr_c2", o_addr, 32'h1);
            end
            if (c == 4) begin
                chk("t1_pc_c4", o_pc, 32'h4);
                chk("t1_inst_c4", o_out, 32'h00628233);
                chk("t1_addr_c4", o_addr, 32'h2);
            end
        end

        // decode stalled: buffer fills and fetch stops
        do_reset(1'b0);
        repeat (20) step(1'b0, 32'h0, 1'b0);
        chk("t2_req_count", n_req, 2);
        chk("t2_full_noreq", {31'b0, o_req}, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        chk("t2_drain0", o_pc, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        chk("t2_drain4", o_pc, 32'h4);
        chk("t2_resume_addr", o_addr, 32'h2);
        chk("t2_resume_req", {31'b0, o_req}, 32'h1);
        repeat (4) step(1'b0, 32'h0, 1'b1);

        // redirect while a slow read is outstanding
        do_reset(1'b0);
        lat = 3;
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h40, 1'b1);
        run_until_req("t3_req_seen", 1'b1);
        chk("t3_addr", o_addr, 32'h10);
        for (int i = 0; i < 10 && !o_valid; i++) step(1'b0, 32'h0, 1'b1);
        chk("t3_first_pc", o_pc, 32'h40);

        // redirect coincident with response and pop
        do_reset(1'b0);
        lat = 2;
        hit = 0;
        for (int i = 0; i < 30; i++) begin
            if (mem_pend && cyc == mem_due && m_q.size() > 0) begin
                step(1'b1, 32'h80, 1'b1);
                hit = 1;
                break;
            end
            step(1'b0, 32'h0, 1'b0);
        end
        chk("t4_hit", {31'b0, hit}, 32'h1);
        step(1'b0, 32'h0, 1'b1);
        chk("t4_flushed", {31'b0, o_valid}, 32'h0);
        chk("t4_target", o_addr, 32'h20);

        // misaligned redirect target and PC wrap
        lat = 1;
        step(1'b1, 32'h103, 1'b1);
        run_until_req("t5_req_seen", 1'b1);
        chk("t5_addr", o_addr, 32'h40);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("t5_pc", o_pc, 32'h100);
        chk("t5_inst", o_out, rom(32'h40));
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        run_until_req("t5w_req_seen", 1'b1);
        chk("t5w_addr", o_addr, 32'h3FFF_FFFF);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("t5w_pc", o_pc, 32'hFFFF_FFFC);
        chk("t5w_wrap_addr", o_addr, 32'h0);

        // reset while waiting with one buffered entry; late response ignored
        do_reset(1'b0);
        lat = 3;
        hit = 0;
        for (int i = 0; i < 30; i++) begin
            if (m_out && m_q.size() == 1) begin
                hit = 1;
                break;
            end
            step(1'b0, 32'h0, 1'b0);
        end
        chk("t6_setup", {31'b0, hit}, 32'h1);
        do_reset(1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("t6_restart_req", {31'b0, o_req}, 32'h1);
        chk("t6_restart_addr", o_addr, RESET_PC >> 2);
        repeat (8) step(1'b0, 32'h0, 1'b1);

        // randomized traffic
        do_reset(1'b0);
        rand_lat = 1;
        spur_en = 1;
        for (int i = 0; i < 1500; i++) begin
            logic        rv, rdy;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 99) < 5);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            rdy = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 499) == 0) do_reset(1'($urandom_range(0, 1)));
            else step(rv, rpc, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
